clock_switch_ctrl: RTL and testbench
====================================

CLOCK_SWITCH_CTRL -- requirements
Module: clock_switch_ctrl

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth for each toggle input (minimum 2).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, clk cycles without a toggle edge before a clock is declared dead.
REQ-003 SHALL have parameter HOLD_CYCLES, default 8, minimum dwell in clk cycles after every sel change.
REQ-004 SHALL have port clk, input, 1, single reference clock; all logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port clk1_tog, input, 1, divide-by-2 toggle from clk_1 domain, asynchronous to clk.
REQ-007 SHALL have port clk2_tog, input, 1, divide-by-2 toggle from clk_2 domain, asynchronous to clk.
REQ-008 SHALL have port req_sel, input, 1, requested source: 0 = clk_1, 1 = clk_2.
REQ-009 SHALL have port auto_en, input, 1, 1 enables automatic failover.
REQ-010 SHALL have port sel, output, 1, registered select driving the glitch-free clock mux.
REQ-011 SHALL have port busy, output, 1, high during the post-switch dwell.
REQ-012 SHALL have ports clk1_ok and clk2_ok, output, 1 each, clock-alive status.
REQ-013 SHALL have port fail_pulse, output, 1, one-cycle pulse on each automatic failover.

Function
REQ-014 Each toggle SHALL pass through a SYNC_STAGES flop synchronizer, then an edge-detect register; any transition (either polarity) yields a one-cycle edge pulse.
REQ-015 A toggle transition sampled at edge k SHALL make clkN_ok = 1 visible after edge k+SYNC_STAGES+1.
REQ-016 Each monitor SHALL hold a saturating idle counter: cleared on an edge pulse, otherwise incremented and saturating at TIMEOUT_CYCLES.
REQ-017 clkN_ok SHALL drop to 0 on the cycle the idle counter reaches TIMEOUT_CYCLES.
REQ-018 The FSM SHALL have states ON1 (sel=0, busy=0), HOLD2 (sel=1, busy=1), ON2 (sel=1, busy=0) and HOLD1 (sel=0, busy=1).
REQ-019 target SHALL be defined as follows: if auto_en=1, the current source is not ok and the other source is ok, target = other source; otherwise target = req_sel.
REQ-020 From ON1, if target=1 and clk2_ok=1, the FSM SHALL go to HOLD2 and sel SHALL become 1 on the same edge; ON2 -> HOLD1 SHALL be symmetric.
REQ-021 No switch SHALL ever be made to a source whose ok is 0; if both sources are dead, sel SHALL hold.
REQ-022 A HOLD state SHALL last exactly HOLD_CYCLES cycles and then enter the matching ON state.
REQ-023 Inputs SHALL be ignored during HOLD; a request still pending on exit SHALL be evaluated in the first ON cycle.
REQ-024 fail_pulse SHALL be 1 for exactly the cycle of a transition to HOLD caused by the failover clause of REQ-019 with target != req_sel.
REQ-025 A simultaneous req_sel change and failure in the same cycle SHALL resolve per REQ-019 (failover wins).

Reset
REQ-026 On reset the FSM SHALL enter ON1, with sel=0, busy=0 and fail_pulse=0.
REQ-027 On reset the synchronizers SHALL be set to 0, idle counters to TIMEOUT_CYCLES, and clk1_ok=clk2_ok=0.
REQ-028 Reset asserted mid-HOLD SHALL abort the dwell immediately; the FSM SHALL be in ON1 on the next cycle.
REQ-029 After reset, the FSM SHALL stay in ON1 until a switch condition of REQ-020 holds.

Structure
REQ-030 Package clk_sw_pkg SHALL hold the FSM state typedef (ON1, HOLD2, ON2, HOLD1) and the default parameter constants.
REQ-031 Sub-module clk_activity_mon (synchronizer, edge detect, idle counter, ok flag) SHALL be instantiated twice.
REQ-032 The hold counter SHALL be clog2(HOLD_CYCLES+1) bits wide and the idle counter clog2(TIMEOUT_CYCLES+1) bits wide.

Verification
REQ-033 Reset, then toggle clk1_tog every 3 cycles -> clk1_ok=1 three cycles after the first transition; sel=0 throughout.
REQ-034 Both clocks alive, req_sel 0->1 -> sel=1 and busy=1 on the next edge, busy=0 after 8 cycles, state ON2.
REQ-035 req_sel toggles 1->0 during HOLD2 -> ignored until ON2, then HOLD1 entered on the first ON2 cycle.
REQ-036 auto_en=1, on clk_2 with req_sel=1, clk2_tog stopped -> clk2_ok=0 after 16 idle cycles, fail_pulse for 1 cycle, sel=0.
REQ-037 Both toggles stopped, req_sel=1 -> sel stays 0, no fail_pulse; reset asserted at HOLD2 cycle 4 -> ON1 and sel=0 on the next cycle.

Source files
------------

// File: rtl/clk_sw_pkg.sv
// Shared types and default constants for the clock switch controller.
package clk_sw_pkg;

  localparam int unsigned SyncStagesDef    = 2;
  localparam int unsigned TimeoutCyclesDef = 16;
  localparam int unsigned HoldCyclesDef    = 8;

  typedef enum logic [1:0] {
    On1,
    Hold2,
    On2,
    Hold1
  } sw_state_e;

endpackage

// File: rtl/clk_activity_mon.sv
// Liveness monitor for one divide-by-2 toggle: synchronizer, edge detect,
// saturating idle counter and alive flag.
module clk_activity_mon
  import clk_sw_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = SyncStagesDef,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDef
) (
  input  logic clk,
  input  logic reset,
  input  logic tog,
  output logic ok
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   edge_q;
  logic [CntW-1:0]        idle_q;

  // Idle counter starts saturated so the clock reads dead until a real edge is seen.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      edge_q <= 1'b0;
      idle_q <= CntMax;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tog};
      prev_q <= sync_q[SYNC_STAGES-1];
      edge_q <= sync_q[SYNC_STAGES-1] ^ prev_q;
      if (edge_q) begin
        idle_q <= '0;
      end else if (idle_q != CntMax) begin
        idle_q <= idle_q + 1'b1;
      end
    end
  end

  assign ok = (idle_q != CntMax);

endmodule

// File: rtl/clock_switch_ctrl.sv
// Select controller for a glitch-free two-source clock mux with a post-switch
// dwell and optional automatic failover to the surviving source.
module clock_switch_ctrl
  import clk_sw_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = SyncStagesDef,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDef,
  parameter int unsigned HOLD_CYCLES    = HoldCyclesDef
) (
  input  logic clk,
  input  logic reset,
  input  logic clk1_tog,
  input  logic clk2_tog,
  input  logic req_sel,
  input  logic auto_en,
  output logic sel,
  output logic busy,
  output logic clk1_ok,
  output logic clk2_ok,
  output logic fail_pulse
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);

  sw_state_e        state_q, state_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             sel_q, sel_d;
  logic             busy_q, busy_d;
  logic             fail_q, fail_d;
  logic             cur_ok, other_ok, failover, target;

  clk_activity_mon #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_mon1 (
    .clk  (clk),
    .reset(reset),
    .tog  (clk1_tog),
    .ok   (clk1_ok)
  );

  clk_activity_mon #(
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_mon2 (
    .clk  (clk),
    .reset(reset),
    .tog  (clk2_tog),
    .ok   (clk2_ok)
  );

  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    fail_d   = 1'b0;
    cur_ok   = sel_q ? clk2_ok : clk1_ok;
    other_ok = sel_q ? clk1_ok : clk2_ok;
    failover = auto_en & ~cur_ok & other_ok;
    target   = failover ? ~sel_q : req_sel;

    unique case (state_q)
      On1: begin
        if (target && clk2_ok) begin
          state_d = Hold2;
          hold_d  = '0;
          fail_d  = failover && (target != req_sel);
        end
      end
      Hold2: begin
        if (hold_q == HoldLast) state_d = On2;
        else                    hold_d  = hold_q + 1'b1;
      end
      On2: begin
        if (!target && clk1_ok) begin
          state_d = Hold1;
          hold_d  = '0;
          fail_d  = failover && (target != req_sel);
        end
      end
      Hold1: begin
        if (hold_q == HoldLast) state_d = On1;
        else                    hold_d  = hold_q + 1'b1;
      end
      default: state_d = On1;
    endcase

    // Outputs are registered so the mux select never glitches on state decode.
    sel_d  = (state_d == Hold2) || (state_d == On2);
    busy_d = (state_d == Hold2) || (state_d == Hold1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= On1;
      hold_q  <= '0;
      sel_q   <= 1'b0;
      busy_q  <= 1'b0;
      fail_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      fail_q  <= fail_d;
    end
  end

  assign sel        = sel_q;
  assign busy       = busy_q;
  assign fail_pulse = fail_q;

endmodule

// File: tb/tb_clock_switch_ctrl.sv
// Scoreboard bench: expectations are queued with a due cycle when stimulus is
// driven and compared on the falling edge of that cycle.
module tb_clock_switch_ctrl;

  localparam int SigSel  = 0;
  localparam int SigBusy = 1;
  localparam int SigOk1  = 2;
  localparam int SigOk2  = 3;
  localparam int SigFail = 4;

  typedef struct {
    string tag;
    int    due;
    int    sig;
    logic  exp;
  } exp_t;

  logic clk = 1'b0;
  logic reset, clk1_tog, clk2_tog, req_sel, auto_en;
  logic sel, busy, clk1_ok, clk2_ok, fail_pulse;
  logic en1, en2;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  clock_switch_ctrl #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(16),
    .HOLD_CYCLES   (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .clk1_tog  (clk1_tog),
    .clk2_tog  (clk2_tog),
    .req_sel   (req_sel),
    .auto_en   (auto_en),
    .sel       (sel),
    .busy      (busy),
    .clk1_ok   (clk1_ok),
    .clk2_ok   (clk2_ok),
    .fail_pulse(fail_pulse)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b, expected %b", tag, cyc, got, exp);
    end
  endtask

  function automatic logic obs(input int sig);
    case (sig)
      SigSel:  return sel;
      SigBusy: return busy;
      SigOk1:  return clk1_ok;
      SigOk2:  return clk2_ok;
      default: return fail_pulse;
    endcase
  endfunction

  task automatic expect_at(input string tag, input int sig, input int delta, input logic exp);
    exp_t e;
    e.tag = tag;
    e.due = cyc + delta;
    e.sig = sig;
    e.exp = exp;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due == cyc) begin
        check_eq(sb[i].tag, obs(sb[i].sig), sb[i].exp);
        sb.delete(i);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (en1 && (cyc % 3 == 0)) clk1_tog = ~clk1_tog;
    if (en2 && (cyc % 3 == 0)) clk2_tog = ~clk2_tog;
  endtask

  task automatic step(input int n);
    repeat (n) tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; clk1_tog = 1'b0; clk2_tog = 1'b0;
    req_sel = 1'b0; auto_en = 1'b0; en1 = 1'b0; en2 = 1'b0;
    step(3);
    expect_at("rst_sel",  SigSel,  0, 1'b0);
    expect_at("rst_busy", SigBusy, 0, 1'b0);
    expect_at("rst_ok1",  SigOk1,  0, 1'b0);
    expect_at("rst_ok2",  SigOk2,  0, 1'b0);
    expect_at("rst_fail", SigFail, 0, 1'b0);
    reset = 1'b0;
    step(2);

    // First transitions on both toggles: ok after sync + edge register + counter clear.
    clk1_tog = ~clk1_tog;
    clk2_tog = ~clk2_tog;
    expect_at("ok1_early", SigOk1, 3, 1'b0);
    expect_at("ok1_up",    SigOk1, 4, 1'b1);
    expect_at("ok2_early", SigOk2, 3, 1'b0);
    expect_at("ok2_up",    SigOk2, 4, 1'b1);
    expect_at("sel_stay0", SigSel, 4, 1'b0);
    en1 = 1'b1;
    en2 = 1'b1;
    step(8);

    // Manual switch to clk_2, then a reversed request during the dwell.
    req_sel = 1'b1;
    expect_at("sw2_sel",       SigSel,  1, 1'b1);
    expect_at("sw2_busy",      SigBusy, 1, 1'b1);
    expect_at("sw2_nofail",    SigFail, 1, 1'b0);
    expect_at("hold2_last",    SigBusy, 8, 1'b1);
    expect_at("on2_busy",      SigBusy, 9, 1'b0);
    expect_at("on2_sel",       SigSel,  9, 1'b1);
    step(3);
    req_sel = 1'b0;
    expect_at("hold2_ignore",  SigSel,  5, 1'b1);
    expect_at("hold2_busy",    SigBusy, 5, 1'b1);
    expect_at("hold1_sel",     SigSel,  7, 1'b0);
    expect_at("hold1_busy",    SigBusy, 7, 1'b1);
    expect_at("hold1_last",    SigBusy, 14, 1'b1);
    expect_at("on1_busy",      SigBusy, 15, 1'b0);
    expect_at("on1_sel",       SigSel,  15, 1'b0);
    step(17);

    // Failover: sit on clk_2, then stop its toggle.
    auto_en = 1'b1;
    req_sel = 1'b1;
    expect_at("auto_on2_sel",  SigSel,  9, 1'b1);
    expect_at("auto_on2_busy", SigBusy, 9, 1'b0);
    step(10);
    en2 = 1'b0;
    step(1);
    clk2_tog = ~clk2_tog;
    expect_at("ok2_last_alive", SigOk2,  19, 1'b1);
    expect_at("ok2_timeout",    SigOk2,  20, 1'b0);
    expect_at("fo_pre_sel",     SigSel,  20, 1'b1);
    expect_at("fo_pre_fail",    SigFail, 20, 1'b0);
    expect_at("fo_sel",         SigSel,  21, 1'b0);
    expect_at("fo_busy",        SigBusy, 21, 1'b1);
    expect_at("fo_pulse",       SigFail, 21, 1'b1);
    expect_at("fo_pulse_end",   SigFail, 22, 1'b0);
    expect_at("fo_hold_last",   SigBusy, 28, 1'b1);
    expect_at("fo_on1_busy",    SigBusy, 29, 1'b0);
    expect_at("fo_no_sw_back",  SigSel,  30, 1'b0);
    expect_at("fo_no_refail",   SigFail, 30, 1'b0);
    step(31);

    // Both sources dead with req_sel=1: select must hold.
    en1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      expect_at("dead_nofail", SigFail, 0, 1'b0);
      expect_at("dead_sel",    SigSel,  0, 1'b0);
      step(5);
    end
    step(1);
    expect_at("dead_ok1",  SigOk1,  0, 1'b0);
    expect_at("dead_ok2",  SigOk2,  0, 1'b0);
    expect_at("dead_sel2", SigSel,  0, 1'b0);
    expect_at("dead_busy", SigBusy, 0, 1'b0);

    // Revive clk_2 alone: failover toward the requested source, no pulse.
    clk2_tog = ~clk2_tog;
    expect_at("rev_ok2",     SigOk2,  4, 1'b1);
    expect_at("rev_sel_pre", SigSel,  4, 1'b0);
    expect_at("rev_sel",     SigSel,  5, 1'b1);
    expect_at("rev_busy",    SigBusy, 5, 1'b1);
    expect_at("rev_nofail",  SigFail, 5, 1'b0);
    expect_at("h2c4_sel",    SigSel,  8, 1'b1);
    expect_at("h2c4_busy",   SigBusy, 8, 1'b1);
    step(8);
    reset = 1'b1;
    expect_at("abort_sel",  SigSel,  1, 1'b0);
    expect_at("abort_busy", SigBusy, 1, 1'b0);
    expect_at("abort_ok2",  SigOk2,  1, 1'b0);
    expect_at("abort_fail", SigFail, 1, 1'b0);
    step(3);
    reset = 1'b0;

    for (int i = 0; i < 100 && sb.size() != 0; i++) tick();
    check_eq("sb_drain", logic'(sb.size() == 0), 1'b1);
    step(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
